// File: rtl/pulse_indicator_pkg.sv
// Shared types and defaults for the pulse indicator driver.
// State encoding, 50 MHz timing defaults and drop counter width.
package pulse_indicator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // 0.5 s on, 0.25 s off at a 50 MHz core clock
    localparam int DEF_ON_CYCLES  = 25000000;
    localparam int DEF_OFF_CYCLES = 12500000;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/ind_down_timer.sv
// Loadable down-counter shared by the ON and GAP phases.
// Holds at zero; zero flag is a plain compare against 0.
module ind_down_timer #(
    parameter int TMR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    // Load wins; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_indicator_driver.sv
// Stretches event pulses into ON bursts with a forced OFF gap, queueing
// events that arrive mid-burst. Optional PULSE_INDICATOR_DROP_CNT_EN.
module pulse_indicator_driver
    import pulse_indicator_pkg::*;
#(
    parameter int ON_CYCLES   = DEF_ON_CYCLES,
    parameter int OFF_CYCLES  = DEF_OFF_CYCLES,
    parameter int MAX_PENDING = 7,
    parameter int TMR_W       = $clog2((ON_CYCLES > OFF_CYCLES ?
                                        ON_CYCLES : OFF_CYCLES) + 1),
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_i,
    output logic              ind_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o
`ifdef PULSE_INDICATOR_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    state_t            state_q;
    state_t            state_d;
    logic              pulse_q;
    logic              ev;
    logic [PEND_W-1:0] pend_q;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              ind_d;
    logic              busy_d;
    logic              start_next;
    logic              busy_ev;
    logic              accept;

    assign ev = pulse_i & ~pulse_q;

    // A burst follows the gap if anything is queued, this cycle's event included
    assign start_next = (state_q == GAP) && tmr_zero &&
                        ((pend_q != '0) || ev);
    assign busy_ev    = ev && (state_q != IDLE);
    // A slot freed by a simultaneous burst start makes room at saturation
    assign accept     = busy_ev && ((pend_q != PEND_MAX) || start_next);

    ind_down_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // State, registered outputs, edge detector and pending queue depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ind_o   <= 1'b0;
            busy_o  <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ind_o   <= ind_d;
            busy_o  <= busy_d;
            pulse_q <= pulse_i;
            pend_q  <= pend_q + PEND_W'(accept) - PEND_W'(start_next);
        end
    end

    // Next state from the current phase and timer expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ev) state_d = ON;
            ON:      if (tmr_zero) state_d = GAP;
            GAP:     if (tmr_zero) state_d = start_next ? ON : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer reload on every phase entry, plus next-cycle output levels
    always_comb begin
        tmr_load = (state_d != IDLE) && (state_d != state_q);
        tmr_val  = (state_d == GAP) ? OFF_LOAD : ON_LOAD;
        ind_d    = (state_d == ON);
        busy_d   = (state_d != IDLE);
    end

    assign pending_o = pend_q;

`ifdef PULSE_INDICATOR_DROP_CNT_EN
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_q;

    assign drop = busy_ev && !accept;

    // Saturating count of events lost to a full queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_pulse_indicator_driver.sv
// Directed bench for pulse_indicator_driver (ON=4, OFF=2, MAX_PENDING=3).
// Per-cycle output logs are compared against hand-derived patterns.
module tb_pulse_indicator_driver;
    import pulse_indicator_pkg::*;

    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse_i = 1'b0;
    logic          ind_o;
    logic          busy_o;
    logic [PW-1:0] pending_o;
`ifdef PULSE_INDICATOR_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_o;
`endif

    int n_chk = 0;
    int n_pass = 0;

    logic [63:0] ind_s;
    logic [63:0] busy_s;
    logic [PW-1:0] plog [64];
    int pmax;

    pulse_indicator_driver #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (2),
        .MAX_PENDING(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_i   (pulse_i),
        .ind_o     (ind_o),
        .busy_o    (busy_o),
        .pending_o (pending_o)
`ifdef PULSE_INDICATOR_DROP_CNT_EN
        ,
        .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pulse_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sample at negedge k, then drive pat[k] for the following posedge
    task automatic play(input logic [63:0] pat, input int n);
        ind_s = '0;
        busy_s = '0;
        pmax = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ind_s[k] = ind_o;
            busy_s[k] = busy_o;
            plog[k] = pending_o;
            if (int'(pending_o) > pmax) pmax = int'(pending_o);
            pulse_i = pat[k];
        end
    endtask

    function automatic int bursts(input logic [63:0] v);
        int c = 0;
        for (int k = 1; k < 64; k++)
            if (v[k] && !v[k-1]) c++;
        return c;
    endfunction

    initial begin
        #12;
        chk("rst_ind", ind_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pend", pending_o, 0);
        rst_n = 1'b1;

        // single event
        do_reset();
        play(64'h1, 10);
        chk("single_ind", ind_s, 64'h1E);
        chk("single_busy", busy_s, 64'h7E);
        chk("single_pmax", pmax, 0);

        // three queued events, one landing on the gap exit
        do_reset();
        play(64'h55, 27);
        chk("queue_ind", ind_s, 64'h79E79E);
        chk("queue_busy", busy_s, 64'h1FFFFFE);
        chk("queue_p3", plog[3], 1);
        chk("queue_p5", plog[5], 2);
        chk("queue_p7", plog[7], 2);
        chk("queue_p13", plog[13], 1);
        chk("queue_p19", plog[19], 0);

        // saturation: event at E10 is dropped
        do_reset();
        play(64'h555, 34);
        chk("sat_p9", plog[9], 3);
        chk("sat_p11", plog[11], 3);
        chk("sat_p13", plog[13], 2);
        chk("sat_p25", plog[25], 0);
        chk("sat_bursts", bursts(ind_s), 5);
        chk("sat_ind", ind_s, 64'h1E79E79E);
        chk("sat_busy", busy_s, 64'h7FFFFFFE);
`ifdef PULSE_INDICATOR_DROP_CNT_EN
        chk("sat_drop", drop_cnt_o, 1);
`endif

        // held level counts once
        do_reset();
        play(64'h3FF, 14);
        chk("held_ind", ind_s, 64'h1E);
        chk("held_busy", busy_s, 64'h7E);
        chk("held_pmax", pmax, 0);

        // gap-exit event with one pending
        do_reset();
        play(64'h45, 22);
        chk("exit1_ind", ind_s, 64'h1E79E);
        chk("exit1_busy", busy_s, 64'h7FFFE);
        chk("exit1_p7", plog[7], 1);
        chk("exit1_p13", plog[13], 0);

        // gap-exit event with nothing pending
        do_reset();
        play(64'h41, 16);
        chk("exit0_ind", ind_s, 64'h79E);
        chk("exit0_busy", busy_s, 64'h1FFE);
        chk("exit0_pmax", pmax, 0);

        // asynchronous reset mid-ON with two pending
        do_reset();
        play(64'h55, 8);
        chk("mid_ind", ind_s[7], 1);
        chk("mid_pend", plog[7], 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ind", ind_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_pend", pending_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        play(64'h0, 12);
        chk("post_ind", ind_s, 0);
        chk("post_busy", busy_s, 0);
        chk("post_pmax", pmax, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
